onchip_ram_avalon_pipe: RTL

//  Parametrised successor to the Nios on-chip memory slave. Byte-enabled single-port RAM behind an

---
 rtl/onchip_ram_pkg.sv | 23 ++
 rtl/onchip_ram_core.sv | 41 ++++
 rtl/onchip_ram_avalon_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the on-chip Avalon RAM slave.
// Defining ONCHIP_RAM_PARITY_EN widens each stored byte lane by one even-parity bit.
package onchip_ram_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

`ifdef ONCHIP_RAM_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif

  // One byte-enable per 8 data bits.
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Even parity: stored bit makes the 9-bit lane have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-lane-enabled single-port synchronous RAM with a registered read port.
// Lane width is configurable so parity bits can ride alongside each data byte.
module onchip_ram_core #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned DEPTH  = 2024,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     we,
  input  logic                     re,
  input  logic [LANES-1:0]         be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [LANES*LANE_W-1:0]  wdata,
  output logic [LANES*LANE_W-1:0]  rdata
);

  localparam int unsigned WordW = LANES * LANE_W;

  logic [WordW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read register only moves on an accepted read, so it holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (en && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_avalon_pipe.sv
// Avalon-MM scratch RAM slave: zero-fill sequencer, byte-enabled writes, pipelined reads.
// Optional per-lane parity checking is enabled by defining ONCHIP_RAM_PARITY_EN.
module onchip_ram_avalon_pipe
  import onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DEPTH        = 2024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_ZERO    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                avs_chipselect,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                avs_waitrequest,
  output logic                init_done,
  output logic                parity_err
);

  localparam int unsigned       BeW      = be_width(DATA_W);
  localparam int unsigned       WordW    = BeW * LANE_W;
  localparam logic [ADDR_W:0]   DepthL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam state_e            RstState = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_e             state_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic               init_done_q;

  logic               filling, in_range, acc, acc_wr, acc_rd;
  logic               ram_we, ram_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [BeW-1:0]     ram_be;
  logic [WordW-1:0]   ram_wdata, ram_rdata;

  logic               v1_q, oor1_q;
  logic [DATA_W-1:0]  data1;
  logic               mism1, perr1;

  logic               vout, perr_out;
  logic [DATA_W-1:0]  rdata_out;

  // Init sequencer: one zero word per enabled cycle, then ready from the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RstState;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_RUN) init_done_q <= 1'b1;
      if (clken && state_q == ST_INIT) begin
        if (cnt_q == LastAddr) begin
          state_q     <= ST_RUN;
          cnt_q       <= '0;
          init_done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign init_done       = init_done_q;
  assign avs_waitrequest = ~init_done_q | ~clken;
  assign filling         = (state_q == ST_INIT);
  assign in_range        = {1'b0, avs_address} < DepthL;
  assign acc             = avs_chipselect & (avs_read | avs_write) & ~avs_waitrequest;
  assign acc_wr          = acc & avs_write;
  assign acc_rd          = acc & avs_read & ~avs_write;

  always_comb begin
    ram_we    = filling | (acc_wr & in_range);
    ram_re    = acc_rd & in_range;
    ram_addr  = filling ? cnt_q : avs_address;
    ram_be    = filling ? '1 : avs_byteenable;
    ram_wdata = '0;
    if (!filling) begin
      for (int unsigned i = 0; i < BeW; i++) begin
`ifdef ONCHIP_RAM_PARITY_EN
        ram_wdata[i*LANE_W +: LANE_W] = {byte_parity(avs_writedata[i*8 +: 8]),
                                         avs_writedata[i*8 +: 8]};
`else
        ram_wdata[i*LANE_W +: LANE_W] = avs_writedata[i*8 +: 8];
`endif
      end
    end
  end

  onchip_ram_core #(
    .LANES  (BeW),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clken),
    .we      (ram_we),
    .re      (ram_re),
    .be      (ram_be),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // Stage 1 tracks the read issued to the RAM; out-of-range reads never touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
    end else if (clken) begin
      v1_q <= acc_rd;
      if (acc_rd) oor1_q <= ~in_range;
    end
  end

  always_comb begin
    data1 = '0;
    mism1 = 1'b0;
    for (int unsigned i = 0; i < BeW; i++) begin
      if (!oor1_q) data1[i*8 +: 8] = ram_rdata[i*LANE_W +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
      mism1 = mism1 | (ram_rdata[i*LANE_W + 8] ^ byte_parity(ram_rdata[i*LANE_W +: 8]));
`endif
    end
    perr1 = mism1 & ~oor1_q;
  end

  if (READ_LATENCY >= 2) begin : g_lat2
    logic              v2_q, perr2_q;
    logic [DATA_W-1:0] rd2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q    <= 1'b0;
        perr2_q <= 1'b0;
        rd2_q   <= '0;
      end else if (clken) begin
        v2_q <= v1_q;
        if (v1_q) begin
          rd2_q   <= data1;
          perr2_q <= perr1;
        end
      end
    end

    assign vout      = v2_q;
    assign rdata_out = rd2_q;
    assign perr_out  = perr2_q;
  end else begin : g_lat1
    assign vout      = v1_q;
    assign rdata_out = data1;
    assign perr_out  = perr1;
  end

  // A stalled pulse is held back until the next enabled cycle rather than repeated.
  assign avs_readdatavalid = vout & clken;
  assign avs_readdata      = rdata_out;
  assign parity_err        = avs_readdatavalid & perr_out;

endmodule
